// File: rtl/win_checker.sv
// Five-in-a-row scanner: walks the four line directions outward from a new stone via the board read port.
// Optional build macro WIN_EXACT_FIVE_EN: only an exact five wins, and each side is probed up to 5 steps.
module win_checker #(
    parameter int BOARD_SIZE = 15,
    parameter int COORD_W    = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [COORD_W-1:0] move_x_i,
    input  logic [COORD_W-1:0] move_y_i,
    input  logic [1:0]         move_colour_i,
    output logic               rd_en_o,
    output logic [COORD_W-1:0] rd_x_o,
    output logic [COORD_W-1:0] rd_y_o,
    input  logic [1:0]         rd_data_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               win_o,
    output logic [1:0]         win_dir_o,
    output logic [3:0]         run_len_o
);

`ifdef WIN_EXACT_FIVE_EN
    localparam logic [2:0] STEP_MAX = 3'd5;
`else
    localparam logic [2:0] STEP_MAX = 3'd4;
`endif

    // Two guard bits keep origin +/- STEP_MAX from wrapping.
    localparam int PW = COORD_W + 2;
    localparam logic signed [PW-1:0] BS = PW'(BOARD_SIZE);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CHECK, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [COORD_W-1:0] ox_q, ox_d, oy_q, oy_d;
    logic [COORD_W-1:0] rd_x_q, rd_x_d, rd_y_q, rd_y_d;
    logic [1:0]         colour_q, colour_d;
    logic [1:0]         dir_q, dir_d;
    logic               side_q, side_d;
    logic [2:0]         step_q, step_d;
    logic [3:0]         count_q, count_d;
    logic               win_q, win_d;
    logic [1:0]         win_dir_q, win_dir_d;
    logic [3:0]         run_len_q, run_len_d;

    logic signed [PW-1:0] ox_s, oy_s, off_s, px, py;
    logic                 onboard, side_end, win_hit;

    always_comb begin
        ox_s  = signed'(PW'(ox_q));
        oy_s  = signed'(PW'(oy_q));
        off_s = side_q ? -signed'(PW'(step_q)) : signed'(PW'(step_q));
        px    = ox_s;
        py    = oy_s;
        case (dir_q)
            2'd0: px = ox_s + off_s;
            2'd1: py = oy_s + off_s;
            2'd2: begin px = ox_s + off_s; py = oy_s + off_s; end
            default: begin px = ox_s + off_s; py = oy_s - off_s; end
        endcase
        onboard = !px[PW-1] && !py[PW-1] && (px < BS) && (py < BS);
    end

    always_comb begin
        state_d   = state_q;
        ox_d      = ox_q;
        oy_d      = oy_q;
        colour_d  = colour_q;
        dir_d     = dir_q;
        side_d    = side_q;
        step_d    = step_q;
        count_d   = count_q;
        win_d     = win_q;
        win_dir_d = win_dir_q;
        run_len_d = run_len_q;
        rd_en_o   = 1'b0;
        rd_x_o    = rd_x_q;
        rd_y_o    = rd_y_q;
        side_end  = 1'b0;
        win_hit   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    ox_d      = move_x_i;
                    oy_d      = move_y_i;
                    colour_d  = move_colour_i;
                    win_d     = 1'b0;
                    win_dir_d = 2'd0;
                    run_len_d = 4'd0;
                    dir_d     = 2'd0;
                    side_d    = 1'b0;
                    step_d    = 3'd1;
                    count_d   = 4'd1;
                    state_d   = (move_colour_i == 2'b00 || move_colour_i == 2'b11) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (onboard) begin
                    rd_en_o = 1'b1;
                    rd_x_o  = px[COORD_W-1:0];
                    rd_y_o  = py[COORD_W-1:0];
                    state_d = S_CHECK;
                end else begin
                    side_end = 1'b1;
                end
            end
            S_CHECK: begin
                if (rd_data_i == colour_q) begin
                    count_d = count_q + 4'd1;
                    step_d  = step_q + 3'd1;
                    if (step_d > STEP_MAX) side_end = 1'b1;
                    else                   state_d  = S_ISSUE;
                end else begin
                    side_end = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef WIN_EXACT_FIVE_EN
        win_hit = (count_d == 4'd5);
`else
        win_hit = (count_d >= 4'd5);
`endif

        // Side and direction changes resolve in the cycle the side ends.
        if (side_end) begin
            if (!side_q) begin
                side_d  = 1'b1;
                step_d  = 3'd1;
                state_d = S_ISSUE;
            end else if (win_hit) begin
                win_d     = 1'b1;
                win_dir_d = dir_q;
                run_len_d = count_d;
                state_d   = S_DONE;
            end else begin
                if (count_d > run_len_q) run_len_d = count_d;
                if (dir_q == 2'd3) begin
                    state_d = S_DONE;
                end else begin
                    dir_d   = dir_q + 2'd1;
                    side_d  = 1'b0;
                    step_d  = 3'd1;
                    count_d = 4'd1;
                    state_d = S_ISSUE;
                end
            end
        end

        rd_x_d = rd_x_o;
        rd_y_d = rd_y_o;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            ox_q      <= '0;
            oy_q      <= '0;
            rd_x_q    <= '0;
            rd_y_q    <= '0;
            colour_q  <= '0;
            dir_q     <= '0;
            side_q    <= 1'b0;
            step_q    <= '0;
            count_q   <= '0;
            win_q     <= 1'b0;
            win_dir_q <= '0;
            run_len_q <= '0;
        end else begin
            state_q   <= state_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
            rd_x_q    <= rd_x_d;
            rd_y_q    <= rd_y_d;
            colour_q  <= colour_d;
            dir_q     <= dir_d;
            side_q    <= side_d;
            step_q    <= step_d;
            count_q   <= count_d;
            win_q     <= win_d;
            win_dir_q <= win_dir_d;
            run_len_q <= run_len_d;
        end
    end

    assign busy_o    = (state_q == S_ISSUE) || (state_q == S_CHECK);
    assign done_o    = (state_q == S_DONE);
    assign win_o     = win_q;
    assign win_dir_o = win_dir_q;
    assign run_len_o = run_len_q;

endmodule
